// File: rtl/i2s_pkg.sv
// i2s_pkg: shared frame-timing scheduler states and default widths.
package i2s_pkg;
    localparam int FRAME_BITS_DEF = 6;
    typedef enum logic [2:0] {
        LOCAL   = 3'd0,
        DRAIN_L = 3'd1,
        GAP_E   = 3'd2,
        EXT     = 3'd3,
        DRAIN_E = 3'd4,
        GAP_L   = 3'd5
    } state_t;
endpackage

// File: rtl/i2s_ext_monitor.sv
// i2s_ext_monitor: watchdog and frame-lock qualification of the external timing source.
module i2s_ext_monitor
    import i2s_pkg::*;
#(
    parameter int FRAME_BITS  = FRAME_BITS_DEF,
    parameter int TIMEOUT_W   = 10,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  ext_en,
    input  logic [FRAME_BITS-1:0] ext_frame_posn,
    output logic                  ext_alive,
    output logic                  qualified
);
    localparam int LW = $clog2(LOCK_FRAMES + 1);
    logic [TIMEOUT_W-1:0] wd;
    logic [LW-1:0] lock;
    // a strobe on the same clock as watchdog saturation keeps the source alive
    assign ext_alive = ext_en || wd != '1;
    assign qualified = lock == LW'(LOCK_FRAMES);
    always_ff @(posedge ck) begin
        if (!rst) begin
            wd   <= '0;
            lock <= '0;
        end else begin
            wd   <= ext_en ? '0 : wd == '1 ? wd : wd + 1'b1;
            lock <= !ext_alive ? '0 :
                    ext_en && ext_frame_posn == '1 && !qualified ? lock + 1'b1 : lock;
        end
    end
endmodule

// File: rtl/i2s_source_sched.sv
// i2s_source_sched: selects local or external I2S frame timing, switching only on
// frame boundaries and falling back to local timing when the external source dies.
module i2s_source_sched
    import i2s_pkg::*;
#(
    parameter int FRAME_BITS  = FRAME_BITS_DEF,
    parameter int TIMEOUT_W   = 10,
    parameter int LOCK_FRAMES = 2,
    parameter int MUTE_FRAMES = 1
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  gen_en,
    input  logic                  gen_ws,
    input  logic [FRAME_BITS-1:0] gen_frame_posn,
    input  logic                  ext_en,
    input  logic                  ext_ws,
    input  logic [FRAME_BITS-1:0] ext_frame_posn,
    input  logic                  force_local,
    output logic                  en,
    output logic                  ws,
    output logic [FRAME_BITS-1:0] frame_posn,
    output logic                  external,
    output logic                  mute
);
    localparam int MW = $clog2(MUTE_FRAMES + 2);
    state_t state, state_n;
    logic ext_alive, qualified, local_end, gen_start, ext_start, ext_end;
    logic use_ext, gap, gap_n, wrap, en_n, ws_n;
    logic [FRAME_BITS-1:0] fp_n;
    logic [MW-1:0] mcnt, mcnt_n;

    i2s_ext_monitor #(
        .FRAME_BITS (FRAME_BITS),
        .TIMEOUT_W  (TIMEOUT_W),
        .LOCK_FRAMES(LOCK_FRAMES)
    ) u_mon (
        .ck            (ck),
        .rst           (rst),
        .ext_en        (ext_en),
        .ext_frame_posn(ext_frame_posn),
        .ext_alive     (ext_alive),
        .qualified     (qualified)
    );

    assign local_end = gen_en && gen_frame_posn == '1;
    assign gen_start = gen_en && gen_frame_posn == '0;
    assign ext_start = ext_en && ext_frame_posn == '0;
    assign ext_end   = ext_en && ext_frame_posn == '1;

    always_comb begin
        state_n = state;
        case (state)
            LOCAL:   state_n = qualified && ext_alive && !force_local ? DRAIN_L : LOCAL;
            DRAIN_L: state_n = !ext_alive || force_local ? LOCAL : local_end ? GAP_E : DRAIN_L;
            GAP_E:   state_n = !ext_alive ? GAP_L : ext_start ? EXT : GAP_E;
            EXT:     state_n = !ext_alive ? GAP_L : force_local ? DRAIN_E : EXT;
            DRAIN_E: state_n = !ext_alive || ext_end ? GAP_L : DRAIN_E;
            GAP_L:   state_n = gen_start ? LOCAL : GAP_L;
            default: state_n = LOCAL;
        endcase
    end

    // gaps hold ws/frame_posn and silence en until the new source's first strobe
    assign use_ext = state inside {GAP_E, EXT, DRAIN_E};
    assign gap     = state inside {GAP_E, GAP_L};
    assign gap_n   = state_n inside {GAP_E, GAP_L};
    assign en_n    = gap && gap_n ? 1'b0 : use_ext ? ext_en : gen_en;
    assign ws_n    = gap && gap_n ? ws : use_ext ? ext_ws : gen_ws;
    assign fp_n    = gap && gap_n ? frame_posn : use_ext ? ext_frame_posn : gen_frame_posn;
    assign wrap    = en && frame_posn == '1;
    assign mcnt_n  = gap || gap_n ? '0 : wrap && mcnt != MW'(MUTE_FRAMES) ? mcnt + 1'b1 : mcnt;

    always_ff @(posedge ck) begin
        if (!rst) begin
            state      <= LOCAL;
            en         <= 1'b0;
            ws         <= 1'b0;
            frame_posn <= '0;
            external   <= 1'b0;
            mute       <= 1'b1;
            mcnt       <= '0;
        end else begin
            state      <= state_n;
            en         <= en_n;
            ws         <= ws_n;
            frame_posn <= fp_n;
            external   <= state_n inside {EXT, DRAIN_E};
            mute       <= gap_n || mcnt_n != MW'(MUTE_FRAMES);
            mcnt       <= mcnt_n;
        end
    end
endmodule

// File: tb/tb_i2s_source_sched.sv
// tb_i2s_source_sched: directed scenarios for the timing-source scheduler, checked
// every cycle against a source/gap behavioural model plus literal expectations.
module tb_i2s_source_sched;
    logic ck = 1'b0, rst = 1'b0, force_local = 1'b0;
    logic gen_en = 1'b0, gen_ws = 1'b0, ext_en = 1'b0, ext_ws = 1'b0;
    logic [5:0] gen_frame_posn = 6'h3f, ext_frame_posn = 6'h3f;
    logic en, ws, external, mute;
    logic [5:0] frame_posn;
    int gdiv = 0, ediv = 5;
    bit ext_run = 1'b0;
    int cyc = 0, last_ext_edge = 0, ext_ends = 0;
    int vectors = 0, errors = 0;
    bit armed = 1'b0, fl_on = 1'b0;
    int fl_len = -1;
    // model: current source, pending drain, waiting-for-start gap
    bit m_ext = 1'b0, m_leave = 1'b0, m_gap = 1'b0;
    int m_silent = 0, m_lock = 0, m_frames = 0;
    logic e_en = 1'b0, e_ws = 1'b0, e_external = 1'b0, e_mute = 1'b1;
    logic [5:0] e_fp = '0;

    i2s_source_sched dut (
        .ck(ck), .rst(rst), .gen_en(gen_en), .gen_ws(gen_ws), .gen_frame_posn(gen_frame_posn),
        .ext_en(ext_en), .ext_ws(ext_ws), .ext_frame_posn(ext_frame_posn),
        .force_local(force_local), .en(en), .ws(ws), .frame_posn(frame_posn),
        .external(external), .mute(mute)
    );

    initial forever #5 ck = ~ck;

    always @(posedge ck) begin
        cyc <= cyc + 1;
        if (ext_en) last_ext_edge <= cyc + 1;
        ext_ends <= !rst ? 0 : (ext_en && ext_frame_posn == 6'h3f) ? ext_ends + 1 : ext_ends;
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit alive, s_en, s_ws, start, fin, was_gap, o_wrap;
        logic [5:0] s_fp;
        if (!rst) begin
            m_ext = 0; m_leave = 0; m_gap = 0; m_silent = 0; m_lock = 0; m_frames = 0;
            e_en = 0; e_ws = 0; e_fp = '0; e_external = 0; e_mute = 1;
            return;
        end
        alive = ext_en || m_silent < 1023;
        s_en = m_ext ? ext_en : gen_en;
        s_ws = m_ext ? ext_ws : gen_ws;
        s_fp = m_ext ? ext_frame_posn : gen_frame_posn;
        start = s_en && s_fp == 0;
        fin = s_en && s_fp == 63;
        o_wrap = e_en && e_fp == 63;
        was_gap = m_gap;
        if (m_gap) begin
            e_en = 0;
            if (m_ext && !alive) m_ext = 0;
            else if (start) begin
                m_gap = 0; e_en = 1; e_ws = s_ws; e_fp = s_fp;
            end
        end else begin
            e_en = s_en; e_ws = s_ws; e_fp = s_fp;
            if (m_ext) begin
                if (!alive || (m_leave && fin)) begin
                    m_gap = 1; m_ext = 0; m_leave = 0;
                end else if (force_local) m_leave = 1;
            end else if (m_leave) begin
                if (!alive || force_local) m_leave = 0;
                else if (fin) begin
                    m_gap = 1; m_ext = 1; m_leave = 0;
                end
            end else if (m_lock >= 2 && alive && !force_local) m_leave = 1;
        end
        e_external = m_ext && !m_gap;
        if (m_gap || was_gap) m_frames = 0;
        else if (o_wrap && m_frames < 1) m_frames++;
        e_mute = m_gap || m_frames < 1;
        if (!alive) m_lock = 0;
        else if (ext_en && ext_frame_posn == 63 && m_lock < 2) m_lock++;
        m_silent = ext_en ? 0 : (m_silent < 1023 ? m_silent + 1 : 1023);
    endtask

    // compare on the falling edge, then advance the model with the inputs of the next edge
    initial forever begin
        @(negedge ck);
        if (armed) begin
            vectors++;
            if ({en, ws, frame_posn, external, mute} !== {e_en, e_ws, e_fp, e_external, e_mute}) begin
                errors++;
                $display("FAIL cycle %0d en/ws/fp/ext/mute: got %b/%b/%0d/%b/%b, expected %b/%b/%0d/%b/%b",
                         cyc, en, ws, frame_posn, external, mute, e_en, e_ws, e_fp, e_external, e_mute);
            end
            if (fl_on && en) begin
                if (frame_posn == 0) begin
                    if (fl_len >= 0) check("frame_length", fl_len, 64);
                    fl_len = 1;
                end else if (fl_len >= 0) fl_len++;
            end
        end
        model_step();
        if (!rst) armed = 1'b1;
    end

    task automatic step();
        @(posedge ck);
        #1;
        gdiv = (gdiv == 11) ? 0 : gdiv + 1;
        gen_en = (gdiv == 0);
        if (gen_en) gen_frame_posn = gen_frame_posn + 1'b1;
        gen_ws = gen_frame_posn[5];
        if (ext_run) begin
            ediv = (ediv == 11) ? 0 : ediv + 1;
            ext_en = (ediv == 0);
            if (ext_en) ext_frame_posn = ext_frame_posn + 1'b1;
            ext_ws = ext_frame_posn[5];
        end else ext_en = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int n, gap_len, max_gap;
        bit saw_ext;
        // reset, external source held off for four local frames
        steps(3);
        check("rst_en", en, 0);
        check("rst_external", external, 0);
        check("rst_mute", mute, 1);
        rst = 1'b1;
        steps(4 * 768);
        check("t1_mute_released", mute, 0);
        check("t1_external", external, 0);
        // external released: qualify, drain local, gap, first ext strobe at posn 0
        ext_run = 1'b1;
        for (n = 0; n < 5000 && !external; n++) step();
        check("t2_ext_wait", int'(n < 5000), 1);
        check("t2_first_en", en, 1);
        check("t2_first_posn", frame_posn, 0);
        check("t2_mute_at_switch", mute, 1);
        for (n = 0; n < 1000 && mute; n++) step();
        check("t2_mute_wait", int'(n < 1000), 1);
        // external stops mid-frame: 1023 silent clocks saturate the watchdog, FSM leaves on the next edge
        for (n = 0; n < 1000 && !(ext_en && ext_frame_posn == 30); n++) step();
        ext_run = 1'b0;
        for (n = 0; n < 1200 && external; n++) step();
        check("t3_loss_wait", int'(n < 1200), 1);
        check("t3_loss_latency", cyc - last_ext_edge, 1024);
        check("t3_mute_on_loss", mute, 1);
        for (n = 0; n < 800 && !en; n++) step();
        check("t3_local_wait", int'(n < 800), 1);
        check("t3_local_posn", frame_posn, 0);
        // requalify, then force local mid ext frame
        ext_run = 1'b1;
        for (n = 0; n < 5000 && !external; n++) step();
        check("t4_ext_wait", int'(n < 5000), 1);
        for (n = 0; n < 1000 && mute; n++) step();
        for (n = 0; n < 1000 && !(ext_en && ext_frame_posn == 10); n++) step();
        force_local = 1'b1;
        fl_len = -1;
        fl_on = 1'b1;
        for (n = 0; n < 1000 && external; n++) step();
        check("t4_drain_wait", int'(n < 1000), 1);
        check("t4_last_ext_is_63", int'(en && frame_posn == 63), 1);
        steps(1700);
        fl_on = 1'b0;
        // ext dies while waiting in the gap for its frame start
        for (n = 0; n < 1000 && !(gen_en && gen_frame_posn == 62); n++) step();
        force_local = 1'b0;
        ext_run = 1'b0;
        saw_ext = 1'b0;
        gap_len = 0;
        max_gap = 0;
        for (int i = 0; i < 2700; i++) begin
            step();
            if (external) saw_ext = 1'b1;
            gap_len = en ? 0 : gap_len + 1;
            if (gap_len > max_gap) max_gap = gap_len;
        end
        check("t5_never_external", saw_ext, 0);
        check("t5_long_gap", int'(max_gap >= 1000), 1);
        check("t5_mute_released", mute, 0);
        // reset while draining ext
        ext_run = 1'b1;
        for (n = 0; n < 5000 && !external; n++) step();
        check("t6_ext_wait", int'(n < 5000), 1);
        for (n = 0; n < 1000 && !(ext_en && ext_frame_posn == 10); n++) step();
        force_local = 1'b1;
        steps(5);
        rst = 1'b0;
        step();
        check("t6_rst_en", en, 0);
        check("t6_rst_ws", ws, 0);
        check("t6_rst_posn", frame_posn, 0);
        check("t6_rst_external", external, 0);
        check("t6_rst_mute", mute, 1);
        rst = 1'b1;
        force_local = 1'b0;
        for (n = 0; n < 5000 && !external; n++) step();
        check("t6_requal_wait", int'(n < 5000), 1);
        check("t6_requal_frames", int'(ext_ends >= 2), 1);
        steps(50);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
